// File: rtl/mips_ctrl_pkg.sv
// Shared constants, state encoding and opcode classification for the
// multi-cycle MIPS controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] ALU_ADD = 6'b001000;
  localparam logic [5:0] ALU_SUB = 6'b000100;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB_ALU,
    ST_ADDR,
    ST_MEM,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_t;

  // Unsupported opcodes map back to FETCH, which the decoder treats as illegal.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI: nxt = ST_EXEC;
      OP_LW, OP_SW:               nxt = ST_ADDR;
      OP_BEQ:                     nxt = ST_BRANCH;
      OP_J, OP_JAL:               nxt = ST_JUMP;
      default:                    nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the
// cycle on which the wait budget runs out.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt_q;
  logic [CW-1:0] wait_cnt_d;

  assign expire = active && !ready && (wait_cnt_q == LAST);

  always_comb begin
    wait_cnt_d = '0;
    if (active && !ready && !expire) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a
// timed memory handshake and a retired-instruction counter.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [5:0]       alu_op,
  output logic             retire,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             bus_error_q, bus_error_d;
  logic             mem_wait;
  logic             expire;

  assign mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .active(mem_wait),
    .ready (mem_ready),
    .expire(expire)
  );

  // Control word and next state are decoded from the current state; reset
  // forces the whole control word low so an aborted instruction writes nothing.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bus_error_d = bus_error_q;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_ALU;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_dst     = REG_DST_RT;
    mem_to_reg  = M2R_ALUOUT;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_RT;
    alu_op      = 6'b000000;
    retire      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (expire) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_DECODE: begin
        op_d      = opcode;
        alu_src_b = ALUB_IMM_SH2;
        alu_op    = ALU_ADD;
        state_d   = decode_next(opcode);
        illegal   = (decode_next(opcode) == ST_FETCH);
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (op_q == OP_RTYPE) ? ALUB_RT : ALUB_IMM;
        alu_op    = op_q;
        state_d   = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = ALU_ADD;
        state_d   = ST_MEM;
      end
      ST_MEM: begin
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB_MEM;
          end else begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        end else if (expire) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        if (op_q == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
        end
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    if (reset) begin
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 6'b000000;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) begin
      instr_count_d = instr_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      op_q          <= 6'b000000;
      instr_count_q <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      instr_count_q <= instr_count_d;
      bus_error_q   <= bus_error_d;
    end
  end

  assign bus_error   = bus_error_q && !reset;
  assign instr_count = reset ? '0 : instr_count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath: one shared instruction/data memory, one ALU, one register file, stepped through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Replaces single-cycle opcode decode with a registered FSM.
- Waits on a memory ready handshake, with a timeout.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready before bus error (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction [31:26] from IR/memory bus.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed current read/write this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  2  00 ALU result (PC+4), 01 ALU-out register (branch target), 10 jump target.
- ir_write  out  1  instruction register load.
- iord  out  1  memory address: 0 PC, 1 ALU-out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALU-out, 01 MDR, 10 PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 PC, 1 rs.
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- alu_op  out  6  ALU controller code.
- retire  out  1  one-cycle pulse on final cycle of each instruction.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- bus_error  out  1  sticky, set on memory timeout.
- instr_count  out  CNT_W  retired instructions; wraps to 0.

Behaviour:
- Reset:
  - While reset is high at a clock edge: state <= FETCH, op_q <= 0, wait_cnt <= 0, instr_count <= 0, bus_error <= 0.
  - All outputs are 0 in any cycle where reset is high; reset mid-instruction aborts it with no write.
- Output timing:
  - Outputs are decoded combinationally from state, op_q and mem_ready/zero.
  - Any output not listed for a state is 0.
- ALU op codes:
  - ADD = 6'b001000 is used for PC+4, branch target and effective address.
  - EXEC passes op_q (000000 means the ALU controller uses funct).
  - BRANCH uses 6'b000100 (subtract).
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE:
  - op_q <= opcode.
  - alu_src_a=0, alu_src_b=11, alu_op=ADD (ALU-out latches branch target).
  - Next state by opcode:
    - 000000, 001000, 001100 -> EXEC.
    - 100011, 101011 -> ADDR.
    - 000100 -> BRANCH.
    - 000010, 000011 -> JUMP.
    - Other opcodes: illegal=1, retire=0, go to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00 if op_q==0, else 10; alu_op=op_q.
  - Next state WB_ALU.
- WB_ALU:
  - reg_write=1, mem_to_reg=00, reg_dst=01 if R-type, else 00.
  - retire=1, next state FETCH.
- ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=ADD.
  - Next state MEM.
- MEM:
  - iord=1; mem_read=1 for lw, mem_write=1 for sw.
  - Holds while mem_ready=0.
  - When mem_ready=1: lw -> WB_MEM; sw -> retire=1, then FETCH.
- WB_MEM:
  - reg_write=1, reg_dst=00, mem_to_reg=01.
  - retire=1, next state FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=000100, pc_src=01.
  - pc_write=zero (same cycle).
  - retire=1, next state FETCH.
- JUMP:
  - pc_write=1, pc_src=10.
  - jal also asserts reg_write=1, reg_dst=10, mem_to_reg=10.
  - retire=1, next state FETCH.
- Latency with zero wait states:
  - R/addi/andi 4 cycles; lw 5; sw 4; beq 3; j/jal 3.
  - Each mem_ready=0 cycle adds 1.
- Timeout:
  - wait_cnt increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready=1 or state exit.
  - If mem_ready=0 while wait_cnt==MEM_TIMEOUT-1: bus_error <= 1, state <= HALT.
- HALT:
  - All outputs 0, absorbing state; only reset leaves.
- Counter:
  - instr_count increments on retire.
  - At all ones it wraps to 0 with no flag.
- Simultaneous events:
  - mem_ready=1 on the last allowed wait cycle completes the access normally (no error).
  - reset takes priority over everything.

Decomposition:
- Shared package mips_ctrl_pkg:
  - Opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_BEQ, OP_J, OP_JAL.
  - ALU_ADD and ALU_SUB codes.
  - State enum.
  - Mux select constants for pc_src, reg_dst, mem_to_reg, alu_src_b.
- Sub-module mem_wait_timer: wait_cnt plus timeout compare. Inputs: clk, reset, active, ready. Output: expire.
- FSM and output decode stay in this block.

Test Plan:
- Reset, then addi with mem_ready tied 1 -> 4 cycles; reg_write=1 with reg_dst=00 in cycle 4; retire once; instr_count=1.
- lw with 2 mem_ready=0 cycles in MEM -> iord=1 and mem_read held 3 cycles; 7 total cycles; reg_write with mem_to_reg=01 in last cycle.
- beq with zero=1, then beq with zero=0 -> pc_write=1/pc_src=01 in cycle 3 for the first; pc_write=0 in cycle 3 for the second; both retire.
- jal -> cycle 3 asserts pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- Opcode 6'b111111 -> illegal pulse in DECODE; no retire; FETCH next cycle; instr_count unchanged.
- MEM_TIMEOUT=4 with mem_ready=0 in FETCH -> bus_error=1 after 4 cycles; outputs 0 until reset; reset asserted mid-lw returns to FETCH with count 0.
